// File: rtl/hex_page_sequencer.sv
// hex_page_sequencer: pages a 32-bit word onto two hex digits, MS byte first, with dwell and gap timing.
// Optional macro HEX_PAGE_SEQUENCER_AUTOREPEAT_EN: wrap from page 0 back to page 3 indefinitely.
module hex_page_sequencer #(
    parameter int DWELL_CYCLES = 12_000_000,
    parameter int GAP_CYCLES   = 1_200_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [31:0] data_i,
    input  logic        hold_i,
    output logic [3:0]  digit_hi_o,
    output logic [3:0]  digit_lo_o,
    output logic [1:0]  page_o,
    output logic        blank_o,
    output logic        busy_o,
    output logic        done_o
);
    localparam int MAXC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DW_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit HAS_GAP = GAP_CYCLES > 0;
`ifdef HEX_PAGE_SEQUENCER_AUTOREPEAT_EN
    localparam bit AUTOREPEAT = 1'b1;
`else
    localparam bit AUTOREPEAT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t        r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [1:0]    r_page, w_page_n;
    logic [31:0]   r_word, w_word_n;
    logic          w_done_n;
    logic [3:0]    r_hi, r_lo;
    logic          r_blank, r_busy, r_done;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_page_n  = r_page;
        w_word_n  = r_word;
        w_done_n  = 1'b0;
        if (load_i) begin
            w_word_n  = data_i;
            w_page_n  = 2'd3;
            w_cnt_n   = '0;
            w_state_n = SHOW;
        end else if (!hold_i) begin
            case (r_state)
                SHOW: begin
                    if (r_cnt != DW_LAST) begin
                        w_cnt_n = r_cnt + 1'b1;
                    end else begin
                        w_cnt_n  = '0;
                        w_done_n = r_page == 2'd0;
                        if (r_page == 2'd0 && !AUTOREPEAT) w_state_n = IDLE;
                        else if (HAS_GAP) w_state_n = GAP;
                        else w_page_n = r_page - 2'd1;
                    end
                end
                GAP: begin
                    if (r_cnt != GP_LAST) begin
                        w_cnt_n = r_cnt + 1'b1;
                    end else begin
                        w_cnt_n   = '0;
                        w_page_n  = r_page - 2'd1;
                        w_state_n = SHOW;
                    end
                end
                default: ;
            endcase
        end
    end

    // Digits follow the byte at the current page; during GAP the page has not moved yet, so they hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_page  <= 2'd0;
            r_word  <= '0;
            r_hi    <= 4'd0;
            r_lo    <= 4'd0;
            r_blank <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_page  <= w_page_n;
            r_word  <= w_word_n;
            r_hi    <= w_word_n[{w_page_n, 3'd7} -: 4];
            r_lo    <= w_word_n[{w_page_n, 3'd3} -: 4];
            r_blank <= w_state_n != SHOW;
            r_busy  <= w_state_n != IDLE;
            r_done  <= w_done_n;
        end
    end

    assign digit_hi_o = r_hi;
    assign digit_lo_o = r_lo;
    assign page_o     = r_page;
    assign blank_o    = r_blank;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
endmodule

// File: tb/tb_hex_page_sequencer.sv
// tb_hex_page_sequencer: two instances (DWELL=4 with GAP=2 and GAP=0) checked against a timeline model.
module tb_hex_page_sequencer;
    localparam int D = 4;
`ifdef HEX_PAGE_SEQUENCER_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_i = 1'b0;
    logic        hold_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [3:0]  hi [2];
    logic [3:0]  lo [2];
    logic [1:0]  pg [2];
    logic        bl [2];
    logic        bz [2];
    logic        dn_o [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hex_page_sequencer #(.DWELL_CYCLES(4), .GAP_CYCLES(2)) u0 (
        .clk(clk), .reset(reset), .load_i(load_i), .data_i(data_i), .hold_i(hold_i),
        .digit_hi_o(hi[0]), .digit_lo_o(lo[0]), .page_o(pg[0]),
        .blank_o(bl[0]), .busy_o(bz[0]), .done_o(dn_o[0])
    );
    hex_page_sequencer #(.DWELL_CYCLES(4), .GAP_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .load_i(load_i), .data_i(data_i), .hold_i(hold_i),
        .digit_hi_o(hi[1]), .digit_lo_o(lo[1]), .page_o(pg[1]),
        .blank_o(bl[1]), .busy_o(bz[1]), .done_o(dn_o[1])
    );

    // Model: t counts unheld cycles since load; each page occupies a DWELL slot followed by a GAP slot.
    int          t [2];
    bit          act [2];
    bit          dn [2];
    logic [31:0] mw;

    function automatic int gap_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mw = '0;
            for (int i = 0; i < 2; i++) begin
                t[i] = 0;
                act[i] = 0;
                dn[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int p, fin;
                p = D + gap_of(i);
                fin = 3 * p + D;
                dn[i] = 0;
                if (load_i) begin
                    act[i] = 1;
                    t[i] = 0;
                end else if (act[i] && !hold_i) begin
                    t[i]++;
                    if (t[i] == fin) begin
                        dn[i] = 1;
                        if (!AR) act[i] = 0;
                    end
                    if (t[i] == 4 * p) t[i] = 0;
                end
            end
            if (load_i) mw = data_i;
        end
    end

    function automatic logic [12:0] expv(input int i);
        int p, k, r;
        logic [1:0] page;
        logic blank, busy;
        logic [7:0] b;
        p = D + gap_of(i);
        if (!act[i]) begin
            page = 2'd0;
            blank = 1'b1;
            busy = 1'b0;
        end else begin
            k = t[i] / p;
            r = t[i] % p;
            page = 2'(3 - k);
            blank = r >= D;
            busy = 1'b1;
        end
        b = 8'(mw >> (8 * page));
        return {b, page, blank, busy, dn[i]};
    endfunction

    function automatic logic [12:0] obs(input int i);
        return {hi[i], lo[i], pg[i], bl[i], bz[i], dn_o[i]};
    endfunction

    task automatic cyc(input bit ld, input logic [31:0] d, input bit hd);
        @(negedge clk);
        load_i = ld;
        data_i = d;
        hold_i = hd;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== 13'h004) begin
                errors++;
                $display("FAIL reset dut%0d got %h expected %h", i, obs(i), 13'h004);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            cyc(0, $urandom, 1'($urandom));
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL idle dut%0d got %h expected %h", i, obs(i), expv(i));
                end
            end
        end
    endtask

    task automatic test_sequence;
        int nb0, nb1, nd0, nbl1;
        nb0 = 0; nb1 = 0; nd0 = 0; nbl1 = 0;
        cyc(1, 32'h12345678, 0);
        checks++;
        if ({hi[0], lo[0], pg[0], bl[0]} !== {8'h12, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL first_page got %h/%h page %0d blank %b expected 1/2 page 3 blank 0",
                     hi[0], lo[0], pg[0], bl[0]);
        end
        for (int n = 0; n < 31; n++) begin
            if (n > 0) cyc(0, $urandom, 0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL seq dut%0d cyc %0d got %h expected %h", i, n, obs(i), expv(i));
                end
            end
            nb0 += int'(bz[0]);
            nb1 += int'(bz[1]);
            nd0 += int'(dn_o[0]);
            nbl1 += int'(bz[1] && bl[1]);
        end
        checks++;
        if (nbl1 != 0) begin
            errors++;
            $display("FAIL gapless_blank got %0d blank cycles expected 0", nbl1);
        end
`ifndef HEX_PAGE_SEQUENCER_AUTOREPEAT_EN
        checks += 3;
        if (nb0 != 22) begin
            errors++;
            $display("FAIL busy_len got %0d expected 22", nb0);
        end
        if (nb1 != 16) begin
            errors++;
            $display("FAIL busy_len_gapless got %0d expected 16", nb1);
        end
        if (nd0 != 1) begin
            errors++;
            $display("FAIL done_count got %0d expected 1", nd0);
        end
`endif
    endtask

    task automatic test_hold;
        int nb0, nb1;
        nb0 = 0; nb1 = 0;
        cyc(1, $urandom, 0);
        for (int n = 0; n < 61; n++) begin
            if (n > 0) cyc(0, $urandom, n >= 8 && n < 13);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL hold dut%0d cyc %0d got %h expected %h", i, n, obs(i), expv(i));
                end
            end
            nb0 += int'(bz[0]);
            nb1 += int'(bz[1]);
        end
`ifndef HEX_PAGE_SEQUENCER_AUTOREPEAT_EN
        checks += 2;
        if (nb0 != 27) begin
            errors++;
            $display("FAIL hold_delay got %0d expected 27", nb0);
        end
        if (nb1 != 21) begin
            errors++;
            $display("FAIL hold_delay_gapless got %0d expected 21", nb1);
        end
`endif
    endtask

    task automatic test_reload;
        int nd0, n;
        nd0 = 0;
        n = 0;
        cyc(1, $urandom, 0);
        while (!(pg[0] == 2'd1 && !bl[0]) && n < 40) begin
            cyc(0, $urandom, 0);
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL reload_wait got timeout expected page 1 shown");
        end
        cyc(1, 32'hDEADBEEF, 0);
        checks++;
        if ({hi[0], lo[0], pg[0], bl[0], dn_o[0]} !== {8'hDE, 2'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reload got %h/%h page %0d blank %b done %b expected D/E page 3 blank 0 done 0",
                     hi[0], lo[0], pg[0], bl[0], dn_o[0]);
        end
        for (int k = 0; k < 30; k++) begin
            cyc(0, $urandom, 0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL reload_run dut%0d cyc %0d got %h expected %h", i, k, obs(i), expv(i));
                end
            end
            nd0 += int'(dn_o[0]);
        end
        checks++;
        if (nd0 != 1) begin
            errors++;
            $display("FAIL reload_done got %0d expected 1", nd0);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        n = 0;
        cyc(1, $urandom, 0);
        while (!(bl[0] && bz[0]) && n < 20) begin
            cyc(0, $urandom, 0);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL gap_wait got timeout expected gap");
        end
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== 13'h004) begin
                errors++;
                $display("FAIL reset_mid dut%0d got %h expected %h", i, obs(i), 13'h004);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            cyc(0, $urandom, 0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL after_reset dut%0d got %h expected %h", i, obs(i), expv(i));
                end
            end
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 5) == 0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL random dut%0d cyc %0d got %h expected %h", i, n, obs(i), expv(i));
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_sequence;
        test_hold;
        test_reload;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
